// File: rtl/sdp_ram_sync.sv
// Simple dual-port RAM: one write port and one registered read port on a single clock.
// After reset the array is swept to zero before writes are accepted.
module sdp_ram_sync #(
    parameter int unsigned D_WIDTH = 8,
    parameter int unsigned A_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] address_write,
    input  logic [D_WIDTH-1:0] data_write,
    input  logic               write_enable,
    input  logic [A_WIDTH-1:0] address_read,
    output logic [D_WIDTH-1:0] data_read,
    output logic               init_busy
);

    localparam int unsigned DEPTH = 2 ** A_WIDTH;

    logic [D_WIDTH-1:0] r_mem [DEPTH];
    logic [A_WIDTH-1:0] r_sweep_ptr;
    logic               r_busy;
    logic [D_WIDTH-1:0] r_data_read;

    logic               w_mem_we;
    logic [A_WIDTH-1:0] w_mem_addr;
    logic [D_WIDTH-1:0] w_mem_wdata;
    logic               w_sweep_last;

    // The sweep owns the write port while busy; the array is left alone while rst is held.
    always_comb begin
        w_mem_we     = 1'b0;
        w_mem_addr   = address_write;
        w_mem_wdata  = data_write;
        w_sweep_last = (r_sweep_ptr == A_WIDTH'(DEPTH - 1));
        if (!rst) begin
            if (r_busy) begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_sweep_ptr;
                w_mem_wdata = '0;
            end else begin
                w_mem_we    = write_enable;
            end
        end
    end

    // Storage array; no reset so it maps onto RAM macros.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Sweep control and read register; reading the pre-edge array gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_read <= '0;
            r_busy      <= 1'b1;
            r_sweep_ptr <= '0;
        end else if (r_busy) begin
            r_data_read <= '0;
            r_sweep_ptr <= r_sweep_ptr + A_WIDTH'(1);
            if (w_sweep_last) begin
                r_busy <= 1'b0;
            end
        end else begin
            r_data_read <= r_mem[address_read];
        end
    end

    assign data_read = r_data_read;
    assign init_busy = r_busy;

endmodule

// File: tb/tb_sdp_ram_sync.sv
// Directed self-checking bench for sdp_ram_sync: a 12x16 instance and a 4x4 instance.
module tb_sdp_ram_sync;

    logic        clk;
    // Large instance (D_WIDTH=12, A_WIDTH=4)
    logic        rst;
    logic [3:0]  address_write;
    logic [11:0] data_write;
    logic        write_enable;
    logic [3:0]  address_read;
    logic [11:0] data_read;
    logic        init_busy;
    // Small instance (D_WIDTH=4, A_WIDTH=2)
    logic        s_rst;
    logic [1:0]  s_address_write;
    logic [3:0]  s_data_write;
    logic        s_write_enable;
    logic [1:0]  s_address_read;
    logic [3:0]  s_data_read;
    logic        s_init_busy;

    int checks   = 0;
    int failures = 0;
    int n;

    sdp_ram_sync #(12, 4) u_dut (
        .clk           (clk),
        .rst           (rst),
        .address_write (address_write),
        .data_write    (data_write),
        .write_enable  (write_enable),
        .address_read  (address_read),
        .data_read     (data_read),
        .init_busy     (init_busy)
    );

    sdp_ram_sync #(4, 2) u_dut_small (
        .clk           (clk),
        .rst           (s_rst),
        .address_write (s_address_write),
        .data_write    (s_data_write),
        .write_enable  (s_write_enable),
        .address_read  (s_address_read),
        .data_read     (s_data_read),
        .init_busy     (s_init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; address_write = '0; data_write = '0; write_enable = 1'b0; address_read = '0;
        s_rst = 1'b0; s_address_write = '0; s_data_write = '0; s_write_enable = 1'b0; s_address_read = '0;
        #1;

        // 1: one-cycle reset, sweep takes 16 edges, data_read stays 0
        rst = 1'b1; s_rst = 1'b1;
        tick();
        check_eq("reset_busy", 32'(init_busy), 32'd1);
        check_eq("reset_data", 32'(data_read), 32'd0);
        rst = 1'b0; s_rst = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check_eq($sformatf("sweep_busy_%0d", i), 32'(init_busy), 32'd1);
            check_eq($sformatf("sweep_data_%0d", i), 32'(data_read), 32'd0);
        end
        tick();
        check_eq("sweep_done_16", 32'(init_busy), 32'd0);
        check_eq("sweep_done_data", 32'(data_read), 32'd0);

        // 2: cleared word reads zero
        address_read = 4'hB;
        tick();
        check_eq("read_cleared_B", 32'(data_read), 32'h000);

        // 3: write then read back
        write_enable = 1'b1; address_write = 4'hB; data_write = 12'h0C5;
        tick();
        write_enable = 1'b0;
        tick();
        check_eq("read_written_B", 32'(data_read), 32'h0C5);

        // 4: same-edge read and write is read-first
        write_enable = 1'b1; address_write = 4'h3; data_write = 12'hABC; address_read = 4'h3;
        tick();
        check_eq("rdw_old", 32'(data_read), 32'h000);
        write_enable = 1'b0;
        tick();
        check_eq("rdw_new", 32'(data_read), 32'hABC);

        // Seed addr 2 so the restarted sweep has something to clear
        write_enable = 1'b1; address_write = 4'h2; data_write = 12'h777; address_read = 4'h2;
        tick();
        write_enable = 1'b0;
        tick();
        check_eq("seed_addr2", 32'(data_read), 32'h777);

        // 5: reset mid-sweep with writes attempted during the sweep
        rst = 1'b1;
        tick();
        rst = 1'b0;
        write_enable = 1'b1; address_write = 4'h2; data_write = 12'h5A5;
        for (int i = 0; i < 5; i++) tick();
        check_eq("midsweep_busy", 32'(init_busy), 32'd1);
        rst = 1'b1;
        tick();
        check_eq("midsweep_rst_busy", 32'(init_busy), 32'd1);
        rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (init_busy) check_eq($sformatf("restart_data_%0d", n), 32'(data_read), 32'd0);
        end while (init_busy && n < 40);
        check_eq("restart_len", 32'(n), 32'd16);
        write_enable = 1'b0; address_read = 4'h2;
        tick();
        check_eq("addr2_cleared", 32'(data_read), 32'h000);
        address_read = 4'h3;
        tick();
        check_eq("addr3_cleared", 32'(data_read), 32'h000);

        // 6: small instance, sweep of 4 cycles then write/read
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (s_init_busy && n < 20);
        check_eq("small_sweep_len", 32'(n), 32'd4);
        s_write_enable = 1'b1; s_address_write = 2'd3; s_data_write = 4'h5; s_address_read = 2'd3;
        tick();
        check_eq("small_rdw_old", 32'(s_data_read), 32'h0);
        s_write_enable = 1'b0;
        tick();
        check_eq("small_read3", 32'(s_data_read), 32'h5);
        s_address_read = 2'd0;
        tick();
        check_eq("small_read0", 32'(s_data_read), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
